stream_rr_arbiter: RTL and testbench
====================================

Name: stream_rr_arbiter

Overview:
- Round-robin arbiter that shares one registered stream stage between NUM_IN valid/ready requesters.
- Optional packet locking: the grant is held from a packet's first beat until the beat carrying last is accepted.
- The output stage is a one-deep register with full throughput (one beat per cycle).
- Sits upstream of shared pipeline resources: bus masters, shared FIFOs, DMA channels.

Parameters:
- NUM_IN, 4, number of requesters, >=1, need not be a power of two.
- DW, 8, data width per requester.
- PKT_MODE, 1, 1 = honour last_i and lock the grant per packet; 0 = re-arbitrate on every beat and ignore last_i for locking.
- IW, derived: $clog2(NUM_IN), minimum 1; width of the index.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous flush of the output stage and arbiter state.
- valid_i  in  NUM_IN  per-requester valid.
- ready_o  out  NUM_IN  per-requester ready.
- data_i  in  NUM_IN*DW  flattened data; requester i occupies bits [i*DW +: DW].
- last_i  in  NUM_IN  per-requester end-of-packet flag.
- valid_o  out  1  output valid.
- ready_i  in  1  downstream ready.
- data_o  out  DW  output data.
- last_o  out  1  last flag of the output beat.
- idx_o  out  IW  index of the requester that sourced the output beat.

Behaviour:
- Reset: rst_ni asynchronous, active-low; clock clk_i.
  - Reset values: valid_o=0, data_o=0, last_o=0, idx_o=0, state=ARB, rr_ptr=0, lock_idx=0.
- Output register enable: load_en = ~valid_o | ready_i.
  - Output holds valid/data/last/idx stable while valid_o=1 and ready_i=0.
- Accept: accept = valid_i[g] & ready_o[g], where g is the granted index.
  - On accept, next cycle: valid_o=1, data_o=data_i[g], last_o=last_i[g], idx_o=g.
  - If load_en=1 and there is no accept, valid_o<=0.
- Latency: exactly 1 cycle from accept to valid_o.
  - Back-to-back beats with ready_i=1 give 100% throughput.
- ready_o[i] = grant[i] & load_en & ~clear_i.
  - ready_o is combinational and may depend on valid_i of any requester.
  - At most one ready_o bit is high at any time.
- State ARB:
  - grant = first i with valid_i[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_IN.
  - No requesters valid -> grant=0 and all ready_o=0.
  - On accept: rr_ptr <= (g+1) mod NUM_IN. The wrap from NUM_IN-1 to 0 is explicit; no power-of-two assumption.
  - On accept with PKT_MODE=1 and last_i[g]=0: state <= PKT, lock_idx <= g.
- State PKT:
  - grant = one-hot(lock_idx), regardless of valid_i.
  - Bubbles from the locked requester stall the others; no interleaving.
  - rr_ptr is not updated.
  - On accept with last_i[lock_idx]=1: state <= ARB.
- PKT_MODE=0: state is always ARB.
- clear_i=1 (takes priority over any accept in the same cycle):
  - All ready_o=0, so no handshake occurs that cycle.
  - Next cycle: valid_o=0, data_o=0, last_o=0, idx_o=0, state=ARB, rr_ptr=0.
  - A clear mid-packet abandons the packet; the next grant re-arbitrates from index 0.
- Reset mid-operation: immediate return to the reset values; any in-flight beat is lost.
- NUM_IN=1: the arbiter degenerates to a plain registered stream stage; idx_o is constantly 0.
- Requesters must hold valid_i/data_i/last_i stable until accepted; the arbiter does not check this.

Test Plan:
- Reset, then NUM_IN=4, no valids -> valid_o=0, ready_o=4'b0000, idx_o=0; after raising valid_i[2] -> ready_o=4'b0100, and valid_o=1, idx_o=2 one cycle later.
- All four requesters valid, single-beat (last_i=4'b1111), ready_i=1 for 8 cycles -> idx_o sequence 0,1,2,3,0,1,2,3 on consecutive cycles, valid_o held at 1.
- Backpressure: output holding data_o=8'hA5, idx_o=1; ready_i=0 for 3 cycles with all valids high -> data_o/idx_o stable, ready_o=0000 each cycle; ready_i=1 -> next requester (2) loaded the following cycle.
- Packet: requester 2 sends 3 beats (last on beat 3, with a 1-cycle valid gap after beat 1) while requester 0 is continuously valid -> idx_o=2,2,2 with one bubble, then 0; requester 0 gets ready_o=0 throughout the packet.
- Wrap: after a grant to 3, requesters 0 and 3 valid -> 0 is granted next, then 3.
- Clear mid-packet: requester 1 in PKT after beat 1, clear_i pulsed with valid_i[1]=1 -> no accept that cycle, valid_o=0 next cycle; requesters 0 and 1 valid afterwards -> 0 is granted first.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter feeding one registered, full-throughput stream stage.
// In packet mode the grant stays with a requester from its first beat until its last beat is accepted.
module stream_rr_arbiter #(
    parameter int NUM_IN   = 4,
    parameter int DW       = 8,
    parameter bit PKT_MODE = 1'b1,
    parameter int IW       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [NUM_IN-1:0]    valid_i,
    output logic [NUM_IN-1:0]    ready_o,
    input  logic [NUM_IN*DW-1:0] data_i,
    input  logic [NUM_IN-1:0]    last_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DW-1:0]        data_o,
    output logic                 last_o,
    output logic [IW-1:0]        idx_o
);

    typedef enum logic {ARB, PKT} arbState_e;

    arbState_e r_state, w_stateNext;

    logic [IW-1:0]     r_rrPtr, w_rrPtrNext;
    logic [IW-1:0]     r_lockIdx, w_lockIdxNext;
    logic [NUM_IN-1:0] w_grant;
    logic [IW-1:0]     w_grantIdx;
    logic              w_found;
    logic [DW-1:0]     w_selData;
    logic              w_selLast;
    logic              w_loadEn;
    logic              w_accept;

    logic              r_valid;
    logic [DW-1:0]     r_data;
    logic              r_last;
    logic [IW-1:0]     r_idx;

    assign w_loadEn = ~r_valid | ready_i;
    assign ready_o  = w_grant & {NUM_IN{w_loadEn & ~clear_i}};
    assign w_accept = |(valid_i & ready_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ARB;
            r_rrPtr   <= '0;
            r_lockIdx <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_rrPtr   <= w_rrPtrNext;
            r_lockIdx <= w_lockIdxNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_rrPtrNext   = r_rrPtr;
        w_lockIdxNext = r_lockIdx;
        if (clear_i) begin
            w_stateNext   = ARB;
            w_rrPtrNext   = '0;
            w_lockIdxNext = '0;
        end else if (w_accept) begin
            if (r_state == ARB) begin
                w_rrPtrNext = (int'(w_grantIdx) == NUM_IN - 1) ? '0 : w_grantIdx + IW'(1);
                if (PKT_MODE && !w_selLast) begin
                    w_stateNext   = PKT;
                    w_lockIdxNext = w_grantIdx;
                end
            end else if (w_selLast) begin
                w_stateNext = ARB;
            end
        end
    end

    // Second scan overrides the first, so the lowest index at/after the pointer wins before any wrapped one.
    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = '0;
        w_grant    = '0;
        w_selData  = '0;
        w_selLast  = 1'b0;
        if (r_state == PKT) begin
            w_found    = 1'b1;
            w_grantIdx = r_lockIdx;
        end else begin
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (valid_i[i] && (i < int'(r_rrPtr))) begin
                    w_found    = 1'b1;
                    w_grantIdx = IW'(i);
                end
            end
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (valid_i[i] && (i >= int'(r_rrPtr))) begin
                    w_found    = 1'b1;
                    w_grantIdx = IW'(i);
                end
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            w_grant[i] = w_found && (IW'(i) == w_grantIdx);
            if (w_grant[i]) begin
                w_selData = data_i[i*DW +: DW];
                w_selLast = last_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_idx   <= '0;
        end else if (clear_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_idx   <= '0;
        end else if (w_loadEn) begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_data <= w_selData;
                r_last <= w_selLast;
                r_idx  <= w_grantIdx;
            end
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign last_o  = r_last;
    assign idx_o   = r_idx;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: a vector table for round-robin, backpressure and packets,
// plus hand-written clear and asynchronous-reset sequences.
module tb_stream_rr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic [3:0]  valid_i;
    logic [3:0]  ready_o;
    logic [31:0] data_i;
    logic [3:0]  last_i;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  data_o;
    logic        last_o;
    logic [1:0]  idx_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] lst;
        logic       rdy;
        logic [3:0] eRdy;
        logic       eVld;
        logic [1:0] eIdx;
        logic [7:0] eData;
        logic       eLast;
    } vec_t;

    vec_t vecs[$];

    stream_rr_arbiter #(
        .NUM_IN  (4),
        .DW      (8),
        .PKT_MODE(1'b1)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear_i(clear_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .last_i (last_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o (data_o),
        .last_o (last_o),
        .idx_o  (idx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic applyStimulus(input logic c, input logic [3:0] v, input logic [3:0] l, input logic r);
        clear_i = c;
        valid_i = v;
        last_i  = l;
        ready_i = r;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are already driven; check the combinational ready, then clock and check the registered stage.
    task automatic stepAndCheck(input string tag, input logic [3:0] eRdy, input logic eVld,
                                input logic [1:0] eIdx, input logic [7:0] eData, input logic eLast);
        #2;
        checkOutput({tag, " ready_o"}, 32'(ready_o), 32'(eRdy));
        @(posedge clk_i);
        #1;
        checkOutput({tag, " valid_o"}, 32'(valid_o), 32'(eVld));
        if (eVld) begin
            checkOutput({tag, " idx_o"}, 32'(idx_o), 32'(eIdx));
            checkOutput({tag, " data_o"}, 32'(data_o), 32'(eData));
            checkOutput({tag, " last_o"}, 32'(last_o), 32'(eLast));
        end
    endtask

    task automatic addVec(input logic [3:0] v, input logic [3:0] l, input logic r, input logic [3:0] er,
                          input logic ev, input logic [1:0] ei, input logic [7:0] ed, input logic el);
        vec_t t;
        t.vld = v; t.lst = l; t.rdy = r; t.eRdy = er;
        t.eVld = ev; t.eIdx = ei; t.eData = ed; t.eLast = el;
        vecs.push_back(t);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Requester data: 0=10, 1=A5, 2=3C, 3=D2
        data_i = 32'hD23C_A510;
        rst_ni = 1'b0;
        applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1);

        // Idle, then a lone requester, then a grant to 3 so the pointer wraps to 0
        addVec(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
        addVec(4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h3C, 1'b1);
        addVec(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
        addVec(4'b1000, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD2, 1'b1);
        // All four valid for 8 cycles: 0,1,2,3,0,1,2,3
        for (int k = 0; k < 2; k++) begin
            addVec(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1);
            addVec(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA5, 1'b1);
            addVec(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h3C, 1'b1);
            addVec(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD2, 1'b1);
        end
        // Wrap: after 3, requesters 0 and 3 -> 0 then 3
        addVec(4'b1001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1);
        addVec(4'b1001, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD2, 1'b1);
        // Backpressure while holding A5 from requester 1
        addVec(4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA5, 1'b1);
        for (int k = 0; k < 3; k++)
            addVec(4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA5, 1'b1);
        addVec(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h3C, 1'b1);
        // Empty stage accepts even with ready_i low, then holds
        addVec(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
        addVec(4'b0001, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1);
        addVec(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10, 1'b1);
        addVec(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
        // Packet from requester 2 with a bubble; requester 0 must wait
        addVec(4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h3C, 1'b0);
        addVec(4'b0001, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd0, 8'h00, 1'b0);
        addVec(4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h3C, 1'b0);
        addVec(4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h3C, 1'b1);
        addVec(4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1);
        addVec(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);

        #3;
        checkOutput("reset valid_o", 32'(valid_o), 32'd0);
        checkOutput("reset idx_o", 32'(idx_o), 32'd0);
        checkOutput("reset data_o", 32'(data_o), 32'd0);
        checkOutput("reset last_o", 32'(last_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].vld, vecs[i].lst, vecs[i].rdy);
            stepAndCheck($sformatf("vec%0d", i), vecs[i].eRdy, vecs[i].eVld,
                         vecs[i].eIdx, vecs[i].eData, vecs[i].eLast);
        end

        // Clear mid-packet from requester 1, then re-arbitration from index 0
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
        stepAndCheck("clr beat1", 4'b0010, 1'b1, 2'd1, 8'hA5, 1'b0);
        applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b1);
        stepAndCheck("clr pulse", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
        checkOutput("clr idx_o", 32'(idx_o), 32'd0);
        checkOutput("clr data_o", 32'(data_o), 32'd0);
        checkOutput("clr last_o", 32'(last_o), 32'd0);
        applyStimulus(1'b0, 4'b0011, 4'b1111, 1'b1);
        stepAndCheck("clr after0", 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1);
        applyStimulus(1'b0, 4'b0010, 4'b1111, 1'b1);
        stepAndCheck("clr after1", 4'b0010, 1'b1, 2'd1, 8'hA5, 1'b1);

        // Asynchronous reset with a beat in flight
        applyStimulus(1'b0, 4'b0100, 4'b1111, 1'b1);
        stepAndCheck("rst pre", 4'b0100, 1'b1, 2'd2, 8'h3C, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("async rst valid_o", 32'(valid_o), 32'd0);
        checkOutput("async rst idx_o", 32'(idx_o), 32'd0);
        checkOutput("async rst data_o", 32'(data_o), 32'd0);
        applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        stepAndCheck("rst post", 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
